cr_cddip_sa_sched: RTL and testbench
====================================

// Module: cr_cddip_sa_sched
// PURPOSE
//  Snapshot/readout scheduler for the CDDIP statistics aggregator (SA). Merges a periodic timer
//  trigger and a software request into single SA snapshot pulses, waits for the snapshot to settle,
//  then streams every counter out over a valid/ready record port to the telemetry/DMA path.
//  Sits beside cr_cddip_sa_core; drives sa_snap and the counter read index.
// PARAMETERS
//  N_CNTR     64  number of SA counters streamed per snapshot
//  CNT_W      50  counter width
//  SNAP_WAIT  2   cycles from sa_snap pulse to first counter read (>=1)
//  TMR_W      32  period timer width
// PORTS
//  clk            in   1      core clock
//  rst_n          in   1      asynchronous active-low reset
//  cfg_enable     in   1      periodic trigger enable
//  cfg_period     in   TMR_W  cycles between periodic triggers; 0 = periodic off
//  sw_snap_req    in   1      one-cycle software snapshot request
//  sa_snap        out  1      one-cycle snapshot pulse to SA core
//  sa_clear_live  out  1      one-cycle live-counter clear (CR_CDDIP_SA_SCHED_CLEAR_EN only, else tied 0)
//  snap_rd_idx    out  6      counter index to SA snapshot array
//  snap_rd_data   in   CNT_W  sa_snapshot[snap_rd_idx], valid 1 cycle after index
//  out_valid      out  1      record valid
//  out_ready      in   1      record accepted when valid&ready
//  out_data       out  64     {idx[5:0], 8'h0, count[49:0]}
//  out_last       out  1      record is idx N_CNTR-1
//  busy           out  1      state != IDLE
//  overrun_cnt    out  16     saturating count of dropped triggers
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, timer 0, pending 0.
//  Timer: counts while cfg_enable && cfg_period!=0; at count==cfg_period-1 raises tmr_hit, reloads 0.
//   cfg_enable=0 or period=0 holds timer at 0; period change takes effect at next reload.
//  Trigger = tmr_hit | sw_snap_req (same cycle counts as one). If pending==0 -> pending=1;
//   if pending==1 -> overrun_cnt++ (saturates 16'hFFFF). Pending is set even when not IDLE.
//  FSM:
//   IDLE  : pending -> SNAP, clear pending (a same-cycle new trigger re-sets it, no overrun).
//   SNAP  : sa_snap=1 one cycle; wait counter=SNAP_WAIT-1; idx=0 -> WAIT.
//   WAIT  : decrement; at 0 -> FETCH.
//   FETCH : drive snap_rd_idx=idx one cycle -> CAPT.
//   CAPT  : out_data<={idx,8'h0,snap_rd_data}; out_valid=1; out_last=(idx==N_CNTR-1) -> HOLD.
//   HOLD  : out_valid held, out_data stable until out_ready. On accept: out_valid=0 next cycle;
//           out_last -> IDLE else idx++ -> FETCH.
//  Throughput: one record per 3 cycles (FETCH,CAPT,HOLD) with ready high; first record out_valid
//   SNAP_WAIT+2 cycles after sa_snap. out_valid must never drop without handshake.
//  snap_rd_idx holds last value outside FETCH. busy=1 in all states but IDLE.
//  Reset mid-stream: stream aborted, no out_last emitted; downstream discards partial set.
// CONFIGURATION
//  CR_CDDIP_SA_SCHED_CLEAR_EN defined: sa_clear_live pulses in same cycle as sa_snap
//   (read-and-clear); counts accumulate per-interval. Undefined: sa_clear_live constant 0,
//   counters free-run cumulatively. No other behaviour differs.
// STRUCTURE
//  cr_cddip_saPKG: sa_sched_state_e {IDLE,SNAP,WAIT,FETCH,CAPT,HOLD}, sa_sched_rec_t
//   (idx[5:0], rsvd[7:0], count[49:0]), SA_SCHED_OVR_W=16.
//  Sub-module cr_cddip_sa_sched_tmr: period timer, outputs tmr_hit.
// TESTING
//  1 sw_snap_req once, ready=1, snapshot[i]=i*3 -> 1 sa_snap, 64 records idx 0..63, data i*3, last on 63.
//  2 ready toggling 1-of-4 cycles -> out_data stable while valid&!ready; no record lost/duplicated.
//  3 cfg_period=500, enable=1 -> sa_snap every 500 cycles; period=0 -> no further pulses.
//  4 3 sw_snap_req during one stream -> 1 extra snapshot follows, overrun_cnt=2.
//  5 tmr_hit and sw_snap_req same cycle in IDLE -> one sa_snap, overrun_cnt=0.
//  6 rst_n low at idx 20 -> all outputs 0 next edge; new request restarts at idx 0.
//    With CLEAR_EN: sa_clear_live coincident with each sa_snap; without: always 0.

Source files
------------

// File: rtl/cr_cddip_sa_sched_pkg.sv
// Shared types for the SA snapshot/readout scheduler: FSM states, output record layout, widths.
package cr_cddip_sa_sched_pkg;

    localparam int SA_SCHED_OVR_W = 16;
    localparam int SA_SCHED_IDX_W = 6;
    localparam int SA_SCHED_CNT_W = 50;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SNAP  = 3'd1,
        WAIT  = 3'd2,
        FETCH = 3'd3,
        CAPT  = 3'd4,
        HOLD  = 3'd5
    } sa_sched_state_e;

    typedef struct packed {
        logic [SA_SCHED_IDX_W-1:0] idx;
        logic [7:0]                rsvd;
        logic [SA_SCHED_CNT_W-1:0] count;
    } sa_sched_rec_t;

    function automatic logic [SA_SCHED_OVR_W-1:0] sat_inc(input logic [SA_SCHED_OVR_W-1:0] v);
        return (v == {SA_SCHED_OVR_W{1'b1}}) ? v : v + SA_SCHED_OVR_W'(1);
    endfunction

endpackage

// File: rtl/cr_cddip_sa_sched_tmr.sv
// Period timer: tmr_hit_o is combinational, high on the last cycle of each period; no backpressure.
// The period is sampled at the start of every interval so a mid-interval change lands at the next reload.
module cr_cddip_sa_sched_tmr #(
    parameter int TMR_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_enable_i,
    input  logic [TMR_W-1:0] cfg_period_i,
    output logic             tmr_hit_o
);

    localparam logic [TMR_W-1:0] ONE = TMR_W'(1);

    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] per_q, per_d;
    logic [TMR_W-1:0] per_eff;
    logic             run;

    always_comb begin
        run       = cfg_enable_i && (cfg_period_i != '0);
        per_eff   = (cnt_q == '0) ? cfg_period_i : per_q;
        tmr_hit_o = run && (cnt_q == per_eff - ONE);
        per_d     = per_eff;
        cnt_d     = '0;
        if (run && !tmr_hit_o) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            per_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            per_q <= per_d;
        end
    end

endmodule

// File: rtl/cr_cddip_sa_sched.sv
// SA snapshot scheduler: merges timer/software triggers into sa_snap, then streams N_CNTR records,
// first out_valid SNAP_WAIT+2 cycles after sa_snap, one per 3 cycles; holds record until out_ready.
// Optional CR_CDDIP_SA_SCHED_CLEAR_EN: sa_clear_live pulses with sa_snap (read-and-clear mode).
module cr_cddip_sa_sched
    import cr_cddip_sa_sched_pkg::*;
#(
    parameter int N_CNTR    = 64,
    parameter int CNT_W     = 50,
    parameter int SNAP_WAIT = 2,
    parameter int TMR_W     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_enable,
    input  logic [TMR_W-1:0]          cfg_period,
    input  logic                      sw_snap_req,
    output logic                      sa_snap,
    output logic                      sa_clear_live,
    output logic [SA_SCHED_IDX_W-1:0] snap_rd_idx,
    input  logic [CNT_W-1:0]          snap_rd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [63:0]               out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic [SA_SCHED_OVR_W-1:0] overrun_cnt
);

    localparam int WAIT_W = (SNAP_WAIT > 1) ? $clog2(SNAP_WAIT) : 1;
    localparam logic [SA_SCHED_IDX_W-1:0] LAST_IDX = SA_SCHED_IDX_W'(N_CNTR - 1);

    sa_sched_state_e           state_q, state_d;
    logic                      pending_q, pending_d;
    logic [SA_SCHED_OVR_W-1:0] ovr_q, ovr_d;
    logic [WAIT_W-1:0]         wait_q, wait_d;
    logic [SA_SCHED_IDX_W-1:0] idx_q, idx_d;
    logic [SA_SCHED_IDX_W-1:0] rd_idx_q, rd_idx_d;
    sa_sched_rec_t             rec_q, rec_d;
    logic                      vld_q, vld_d;
    logic                      last_q, last_d;
    logic                      tmr_hit;
    logic                      trig;

    cr_cddip_sa_sched_tmr #(.TMR_W(TMR_W)) u_tmr (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_enable_i (cfg_enable),
        .cfg_period_i (cfg_period),
        .tmr_hit_o    (tmr_hit)
    );

    always_comb begin
        trig      = tmr_hit | sw_snap_req;
        state_d   = state_q;
        pending_d = pending_q;
        ovr_d     = ovr_q;
        wait_d    = wait_q;
        idx_d     = idx_q;
        rd_idx_d  = rd_idx_q;
        rec_d     = rec_q;
        vld_d     = vld_q;
        last_d    = last_q;

        // Launching consumes pending; a trigger in that same cycle simply re-arms it.
        if (state_q == IDLE && pending_q) begin
            pending_d = trig;
        end else if (trig) begin
            if (pending_q) ovr_d = sat_inc(ovr_q);
            else           pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pending_q) state_d = SNAP;
            end
            SNAP: begin
                idx_d   = '0;
                wait_d  = WAIT_W'(SNAP_WAIT - 1);
                state_d = (SNAP_WAIT > 1) ? WAIT : FETCH;
            end
            WAIT: begin
                if (wait_q <= WAIT_W'(1)) state_d = FETCH;
                else                      wait_d  = wait_q - WAIT_W'(1);
            end
            FETCH: begin
                rd_idx_d = idx_q;
                state_d  = CAPT;
            end
            CAPT: begin
                rec_d.idx   = idx_q;
                rec_d.rsvd  = 8'h00;
                rec_d.count = SA_SCHED_CNT_W'(snap_rd_data);
                vld_d       = 1'b1;
                last_d      = (idx_q == LAST_IDX);
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    vld_d  = 1'b0;
                    last_d = 1'b0;
                    if (last_q) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + SA_SCHED_IDX_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            ovr_q     <= '0;
            wait_q    <= '0;
            idx_q     <= '0;
            rd_idx_q  <= '0;
            rec_q     <= '0;
            vld_q     <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ovr_q     <= ovr_d;
            wait_q    <= wait_d;
            idx_q     <= idx_d;
            rd_idx_q  <= rd_idx_d;
            rec_q     <= rec_d;
            vld_q     <= vld_d;
            last_q    <= last_d;
        end
    end

    // Index is presented combinationally in FETCH so the array read lands in CAPT.
    assign snap_rd_idx = (state_q == FETCH) ? idx_q : rd_idx_q;
    assign sa_snap     = (state_q == SNAP);
    assign busy        = (state_q != IDLE);
    assign out_valid   = vld_q;
    assign out_data    = rec_q;
    assign out_last    = last_q;
    assign overrun_cnt = ovr_q;

`ifdef CR_CDDIP_SA_SCHED_CLEAR_EN
    assign sa_clear_live = (state_q == SNAP);
`else
    assign sa_clear_live = 1'b0;
`endif

endmodule

// File: tb/tb_cr_cddip_sa_sched.sv
// Scoreboard bench for cr_cddip_sa_sched: SA snapshot model feeds snap_rd_data, expected records
// are queued at each sa_snap and popped on every out_valid&out_ready handshake.
module tb_cr_cddip_sa_sched;

    localparam int N = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_enable = 1'b0;
    logic [31:0] cfg_period = '0;
    logic        sw_snap_req = 1'b0;
    logic        sa_snap;
    logic        sa_clear_live;
    logic [5:0]  snap_rd_idx;
    logic [49:0] snap_rd_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        out_last;
    logic        busy;
    logic [15:0] overrun_cnt;

    cr_cddip_sa_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_enable    (cfg_enable),
        .cfg_period    (cfg_period),
        .sw_snap_req   (sw_snap_req),
        .sa_snap       (sa_snap),
        .sa_clear_live (sa_clear_live),
        .snap_rd_idx   (snap_rd_idx),
        .snap_rd_data  (snap_rd_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .busy          (busy),
        .overrun_cnt   (overrun_cnt)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          snap_seen = 0;
    int          snap_no = 0;
    int          rec_cnt = 0;
    int          last_cnt = 0;
    int          snap_cyc = 0;
    int          rise_lat = -1;
    int          rdy_mode = 0;
    bit          await_rise = 1'b0;
    bit          prev_hold = 1'b0;
    bit          prev_vld = 1'b0;
    logic [63:0] prev_dat = '0;
    logic [64:0] exp_q[$];
    int          snap_cycs[$];
    logic [49:0] snap_arr[N];
    logic [5:0]  idx_s = '0;
    logic [49:0] v;
    logic [64:0] e;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;
    always @(posedge clk) snap_rd_data <= snap_arr[idx_s];

    initial begin
        for (int i = 0; i < N; i++) snap_arr[i] = '0;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 4) == 0);
        end
    end

    always @(negedge clk) begin
        idx_s = snap_rd_idx;
        if (!rst_n) begin
            prev_hold  = 1'b0;
            prev_vld   = 1'b0;
            await_rise = 1'b0;
        end else begin
            if (sa_snap) begin
                snap_seen++;
                snap_cyc = cyc;
                snap_cycs.push_back(cyc);
                await_rise = 1'b1;
                for (int i = 0; i < N; i++) begin
                    v = 50'(i * 3 + snap_no * 1000);
                    snap_arr[i] = v;
                    exp_q.push_back({(i == N - 1), 6'(i), 8'h00, v});
                end
                snap_no++;
            end
            if (sa_snap || sa_clear_live) begin
`ifdef CR_CDDIP_SA_SCHED_CLEAR_EN
                chk("clear_live", 64'(sa_clear_live), 64'(sa_snap));
`else
                chk("clear_live", 64'(sa_clear_live), 64'd0);
`endif
            end
            if (prev_hold) begin
                chk("hold_vld", 64'(out_valid), 64'd1);
                chk("hold_dat", out_data, prev_dat);
            end
            if (out_valid && !prev_vld && await_rise) begin
                rise_lat   = cyc - snap_cyc;
                await_rise = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_rec", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rec_dat", out_data, e[63:0]);
                    chk("rec_last", 64'(out_last), 64'(e[64]));
                    rec_cnt++;
                    if (out_last) last_cnt++;
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_dat  = out_data;
            prev_vld  = out_valid;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sw();
        sw_snap_req = 1'b1;
        step();
        sw_snap_req = 1'b0;
    endtask

    task automatic wait_snaps(input int n, input int budget, input string tag);
        int k = 0;
        while (snap_seen < n && k < budget) begin
            step();
            k++;
        end
        if (snap_seen < n) chk(tag, 64'(snap_seen), 64'(n));
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (busy && k < budget) begin
            step();
            k++;
        end
        if (busy) chk(tag, 64'(busy), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_snap"}, 64'(sa_snap), 64'd0);
        chk({tag, "_clr"}, 64'(sa_clear_live), 64'd0);
        chk({tag, "_idx"}, 64'(snap_rd_idx), 64'd0);
        chk({tag, "_vld"}, 64'(out_valid), 64'd0);
        chk({tag, "_dat"}, out_data, 64'd0);
        chk({tag, "_last"}, 64'(out_last), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_ovr"}, 64'(overrun_cnt), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, r0, l0, k;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("rst");
        rst_n = 1'b1;
        step();

        // single software snapshot, ready always high
        rdy_mode = 0;
        s0 = snap_seen; r0 = rec_cnt; l0 = last_cnt;
        pulse_sw();
        wait_snaps(s0 + 1, 20, "t1_snap_to");
        wait_idle(1000, "t1_idle_to");
        repeat (5) step();
        chk("t1_snaps", 64'(snap_seen - s0), 64'd1);
        chk("t1_recs", 64'(rec_cnt - r0), 64'd64);
        chk("t1_last", 64'(last_cnt - l0), 64'd1);
        chk("t1_lat", 64'(rise_lat), 64'd4);
        chk("t1_q", 64'(exp_q.size()), 64'd0);

        // ready high one cycle in four
        rdy_mode = 1;
        s0 = snap_seen; r0 = rec_cnt; l0 = last_cnt;
        pulse_sw();
        wait_snaps(s0 + 1, 20, "t2_snap_to");
        wait_idle(2000, "t2_idle_to");
        repeat (5) step();
        chk("t2_recs", 64'(rec_cnt - r0), 64'd64);
        chk("t2_last", 64'(last_cnt - l0), 64'd1);
        chk("t2_q", 64'(exp_q.size()), 64'd0);
        chk("t2_ovr", 64'(overrun_cnt), 64'd0);

        // periodic trigger, then period 0 stops it
        rdy_mode = 0;
        s0 = snap_seen;
        snap_cycs.delete();
        cfg_period = 32'd500;
        cfg_enable = 1'b1;
        wait_snaps(s0 + 3, 2000, "t3_snap_to");
        cfg_period = 32'd0;
        if (snap_cycs.size() >= 3) begin
            chk("t3_per1", 64'(snap_cycs[1] - snap_cycs[0]), 64'd500);
            chk("t3_per2", 64'(snap_cycs[2] - snap_cycs[1]), 64'd500);
        end
        repeat (1200) step();
        cfg_enable = 1'b0;
        chk("t3_off", 64'(snap_seen - s0), 64'd3);
        chk("t3_ovr", 64'(overrun_cnt), 64'd0);
        chk("t3_q", 64'(exp_q.size()), 64'd0);

        // three requests during one stream: one extra snapshot, two overruns
        s0 = snap_seen; r0 = rec_cnt;
        pulse_sw();
        wait_snaps(s0 + 1, 20, "t4_snap_to");
        repeat (3) begin
            repeat (20) step();
            pulse_sw();
        end
        wait_snaps(s0 + 2, 1000, "t4_snap2_to");
        wait_idle(1000, "t4_idle_to");
        repeat (30) step();
        chk("t4_snaps", 64'(snap_seen - s0), 64'd2);
        chk("t4_ovr", 64'(overrun_cnt), 64'd2);
        chk("t4_recs", 64'(rec_cnt - r0), 64'd128);
        chk("t4_q", 64'(exp_q.size()), 64'd0);

        rst_n = 1'b0;
        step();
        chk("rst2_ovr", 64'(overrun_cnt), 64'd0);
        exp_q.delete();
        rst_n = 1'b1;
        step();

        // timer hit and software request in the same idle cycle
        s0 = snap_seen;
        cfg_period = 32'd10;
        cfg_enable = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        sw_snap_req = 1'b1;
        step();
        sw_snap_req = 1'b0;
        cfg_enable = 1'b0;
        cfg_period = 32'd0;
        wait_snaps(s0 + 1, 20, "t5_snap_to");
        wait_idle(1000, "t5_idle_to");
        repeat (20) step();
        chk("t5_snaps", 64'(snap_seen - s0), 64'd1);
        chk("t5_ovr", 64'(overrun_cnt), 64'd0);

        // reset in the middle of a stream, then restart from index 0
        s0 = snap_seen;
        pulse_sw();
        wait_snaps(s0 + 1, 20, "t6_snap_to");
        k = 0;
        while (!(out_valid && out_data[63:58] == 6'd20) && k < 500) begin
            step();
            k++;
        end
        chk("t6_reach20", 64'(out_data[63:58]), 64'd20);
        rst_n = 1'b0;
        #1;
        chk_all_zero("t6_rst");
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        s0 = snap_seen; r0 = rec_cnt; l0 = last_cnt;
        pulse_sw();
        wait_snaps(s0 + 1, 20, "t6_snap2_to");
        k = 0;
        while (!out_valid && k < 50) begin
            step();
            k++;
        end
        chk("t6_first_vld", 64'(out_valid), 64'd1);
        chk("t6_first_idx", 64'(out_data[63:58]), 64'd0);
        wait_idle(1000, "t6_idle_to");
        repeat (5) step();
        chk("t6_recs", 64'(rec_cnt - r0), 64'd64);
        chk("t6_last", 64'(last_cnt - l0), 64'd1);
        chk("t6_q", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
